// File: rtl/switch_select_debouncer.sv
// Synchronises and debounces the enable button and two rate switches; an accepted press toggles o_enable.
// Latency c_DEBOUNCE_LIMIT+2 edges from raw change to output; inputs are free-running, so there is no backpressure.
module switch_select_debouncer #(
  parameter int   c_DEBOUNCE_LIMIT = 250,
  parameter logic c_ENABLE_INIT    = 1'b0
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_button_raw,
  input  logic i_switch1_raw,
  input  logic i_switch2_raw,
  output logic o_enable,
  output logic o_switch1,
  output logic o_switch2,
  output logic o_button_pulse
);

  localparam logic [15:0] c_CNT_LAST = 16'(c_DEBOUNCE_LIMIT - 1);

  // Channel index: 0 = button, 1 = switch1, 2 = switch2
  logic [2:0]       raw;
  logic [2:0]       s1;
  logic [2:0]       s2;
  logic [2:0]       stable;
  logic [2:0]       accept;
  logic [2:0][15:0] cnt;
  logic             btn_press;

  assign raw = {i_switch2_raw, i_switch1_raw, i_button_raw};

  always_comb begin
    accept = '0;
    for (int i = 0; i < 3; i++) begin
      accept[i] = (s2[i] != stable[i]) && (cnt[i] == c_CNT_LAST);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      cnt    <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
    end
  end

  // Only the accepted 0->1 transition of the button acts; release is ignored
  assign btn_press = accept[0] & s2[0];

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_enable       <= c_ENABLE_INIT;
      o_button_pulse <= 1'b0;
    end else begin
      o_button_pulse <= btn_press;
      if (btn_press) begin
        o_enable <= ~o_enable;
      end
    end
  end

  assign o_switch1 = stable[1];
  assign o_switch2 = stable[2];

endmodule

// File: tb/tb_switch_select_debouncer.sv
// Directed bench for switch_select_debouncer with a debounce limit of 4.
// A second instance with enable-init 1 shares the inputs and is checked across resets.
module tb_switch_select_debouncer;

  logic clk = 1'b0;
  logic rst;
  logic btn, sw1, sw2;
  logic en0, s1_0, s2_0, pulse0;
  logic en1, s1_1, s2_1, pulse1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  switch_select_debouncer #(.c_DEBOUNCE_LIMIT(4), .c_ENABLE_INIT(1'b0)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_button_raw(btn), .i_switch1_raw(sw1), .i_switch2_raw(sw2),
    .o_enable(en0), .o_switch1(s1_0), .o_switch2(s2_0), .o_button_pulse(pulse0)
  );

  switch_select_debouncer #(.c_DEBOUNCE_LIMIT(4), .c_ENABLE_INIT(1'b1)) dut_init1 (
    .i_clock(clk), .i_reset(rst),
    .i_button_raw(btn), .i_switch1_raw(sw1), .i_switch2_raw(sw2),
    .o_enable(en1), .o_switch1(s1_1), .o_switch2(s2_1), .o_button_pulse(pulse1)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold the button for 'hold' cycles then release for 'idle' cycles, tracking pulses
  task automatic press(input int hold, input int idle, output int pulses,
                       output int pulse_at, output int en_at_pulse, output int en_before);
    logic prev_en;
    pulses = 0; pulse_at = -1; en_at_pulse = -1; en_before = -1;
    btn = 1'b1;
    for (int t = 1; t <= hold + idle; t++) begin
      if (t == hold + 1) btn = 1'b0;
      prev_en = en0;
      tick();
      if (pulse0) begin
        pulses++;
        if (pulse_at < 0) begin
          pulse_at    = t;
          en_at_pulse = int'(en0);
          en_before   = int'(prev_en);
        end
      end
    end
  endtask

  int pulses, pulse_at, en_at, en_prev, viol;

  initial begin
    rst = 1'b1; btn = 1'b0; sw1 = 1'b0; sw2 = 1'b0;

    // Reset values before any clock edge
    #2;
    chk("rst_en0", int'(en0), 0);
    chk("rst_sw1", int'(s1_0), 0);
    chk("rst_sw2", int'(s2_0), 0);
    chk("rst_pulse", int'(pulse0), 0);
    chk("rst_en_init1", int'(en1), 1);
    tick(3);
    chk("rst_en_init1_held", int'(en1), 1);
    rst = 1'b0;
    tick(8);
    chk("post_rst_en0", int'(en0), 0);
    chk("post_rst_en_init1", int'(en1), 1);
    chk("post_rst_pulse", int'(pulse0), 0);

    // Clean switch1 edge: output rises after the 6th edge
    sw1 = 1'b1;
    tick(5);
    chk("sw1_e5", int'(s1_0), 0);
    tick();
    chk("sw1_e6", int'(s1_0), 1);
    chk("sw1_sw2_unchanged", int'(s2_0), 0);
    chk("sw1_en_unchanged", int'(en0), 0);

    // Bouncing switch2: 2-cycle excursions for 20 cycles, then held high
    viol = 0;
    for (int seg = 0; seg < 10; seg++) begin
      sw2 = (seg % 2 == 0) ? 1'b1 : 1'b0;
      for (int c = 0; c < 2; c++) begin
        tick();
        if (s2_0 !== 1'b0) viol++;
      end
    end
    chk("sw2_bounce_rejected", viol, 0);
    sw2 = 1'b1;
    tick(5);
    chk("sw2_final_e5", int'(s2_0), 0);
    tick();
    chk("sw2_final_e6", int'(s2_0), 1);
    chk("sw2_sw1_independent", int'(s1_0), 1);

    // First button press
    press(10, 10, pulses, pulse_at, en_at, en_prev);
    chk("press1_pulses", pulses, 1);
    chk("press1_pulse_edge", pulse_at, 6);
    chk("press1_en_at_pulse", en_at, 1);
    chk("press1_en_before", en_prev, 0);
    chk("press1_en_after_release", int'(en0), 1);

    // Second press toggles back
    press(10, 10, pulses, pulse_at, en_at, en_prev);
    chk("press2_pulses", pulses, 1);
    chk("press2_pulse_edge", pulse_at, 6);
    chk("press2_en_at_pulse", en_at, 0);
    chk("press2_en_after", int'(en0), 0);

    // Glitch rejection: 3 cycles rejected, 4 cycles accepted
    press(3, 10, pulses, pulse_at, en_at, en_prev);
    chk("glitch3_pulses", pulses, 0);
    chk("glitch3_en", int'(en0), 0);
    press(4, 10, pulses, pulse_at, en_at, en_prev);
    chk("glitch4_pulses", pulses, 1);
    chk("glitch4_en", int'(en0), 1);

    // Mid-operation reset: drive switch1 low, then start a new rise and stop at cnt=2
    sw1 = 1'b0;
    tick(10);
    chk("sw1_low_accepted", int'(s1_0), 0);
    sw1 = 1'b1;
    tick(4);
    chk("sw1_midcount_low", int'(s1_0), 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_en", int'(en0), 0);
    chk("async_rst_sw1", int'(s1_0), 0);
    chk("async_rst_sw2", int'(s2_0), 0);
    chk("async_rst_pulse", int'(pulse0), 0);
    chk("async_rst_en_init1", int'(en1), 1);
    tick();
    rst = 1'b0;
    tick(5);
    chk("rel_sw1_e5", int'(s1_0), 0);
    chk("rel_sw2_e5", int'(s2_0), 0);
    tick();
    chk("rel_sw1_e6", int'(s1_0), 1);
    chk("rel_sw2_e6", int'(s2_0), 1);
    chk("rel_en_stays", int'(en0), 0);
    chk("rel_pulse_low", int'(pulse0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
